// File: rtl/mseq_ber_checker.sv
// Receive-side M-sequence BER checker: self-synchronising LFSR replica with
// HUNT/VERIFY/LOCK acquisition, windowed loss-of-lock and saturating counters.
module mseq_ber_checker #(
  parameter int                LFSR_W      = 7,
  parameter logic [LFSR_W-1:0] TAPS        = 7'b1100000,
  parameter int                SYNC_LEN    = 16,
  parameter int                WIN_LEN     = 64,
  parameter int                LOSS_THRESH = 8,
  parameter int                CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_HUNT   = 2'b00;
  localparam logic [1:0] S_VERIFY = 2'b01;
  localparam logic [1:0] S_LOCK   = 2'b10;

  localparam int FILL_W  = $clog2(LFSR_W + 1);
  localparam int MATCH_W = $clog2(SYNC_LEN + 1);
  localparam int WBITS_W = $clog2(WIN_LEN + 1);
  localparam int WERRS_W = $clog2(LOSS_THRESH + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(LFSR_W - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(SYNC_LEN - 1);
  localparam logic [WBITS_W-1:0] WIN_FULL   = WBITS_W'(WIN_LEN);
  localparam logic [WERRS_W-1:0] ERR_LIMIT  = WERRS_W'(LOSS_THRESH);

  logic [1:0]         state, state_n;
  logic [LFSR_W-1:0]  lfsr, lfsr_n, load_val;
  logic [FILL_W-1:0]  fill, fill_n;
  logic [MATCH_W-1:0] match, match_n;
  logic [WBITS_W-1:0] win_bits, win_bits_n;
  logic [WERRS_W-1:0] win_errs, win_errs_n;
  logic [CNT_W-1:0]   bit_cnt_n, err_cnt_n;
  logic               err_flag_n;
  logic               pred, mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    pred       = ^(lfsr & TAPS);
    mismatch   = bit_in ^ pred;
    load_val   = {lfsr[LFSR_W-2:0], bit_in};
    state_n    = state;
    lfsr_n     = lfsr;
    fill_n     = fill;
    match_n    = match;
    win_bits_n = win_bits;
    win_errs_n = win_errs;
    bit_cnt_n  = bit_count;
    err_cnt_n  = err_count;
    err_flag_n = 1'b0;

    if (bit_valid) begin
      case (state)
        S_HUNT: begin
          lfsr_n = load_val;
          if (fill == FILL_LAST) begin
            // An all-zero load would lock the replica up, so keep hunting.
            fill_n = '0;
            if (load_val != '0) begin
              state_n = S_VERIFY;
              match_n = '0;
            end
          end else begin
            fill_n = fill + FILL_W'(1);
          end
        end

        S_VERIFY: begin
          lfsr_n = {lfsr[LFSR_W-2:0], pred};
          if (mismatch) begin
            state_n = S_HUNT;
            fill_n  = '0;
          end else if (match == MATCH_LAST) begin
            state_n    = S_LOCK;
            win_bits_n = '0;
            win_errs_n = '0;
          end else begin
            match_n = match + MATCH_W'(1);
          end
        end

        S_LOCK: begin
          // Replica free-runs so received errors never corrupt its state.
          lfsr_n     = {lfsr[LFSR_W-2:0], pred};
          bit_cnt_n  = sat_inc(bit_count);
          win_bits_n = win_bits + WBITS_W'(1);
          if (mismatch) begin
            err_cnt_n  = sat_inc(err_count);
            win_errs_n = win_errs + WERRS_W'(1);
            err_flag_n = 1'b1;
          end
          if (win_errs_n == ERR_LIMIT) begin
            state_n    = S_HUNT;
            fill_n     = '0;
            win_bits_n = '0;
            win_errs_n = '0;
          end else if (win_bits_n == WIN_FULL) begin
            win_bits_n = '0;
            win_errs_n = '0;
          end
        end

        default: begin
          state_n = S_HUNT;
          fill_n  = '0;
        end
      endcase
    end

    if (clear) begin
      bit_cnt_n = '0;
      err_cnt_n = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_HUNT;
      lfsr      <= '0;
      fill      <= '0;
      match     <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      bit_count <= '0;
      err_count <= '0;
      err_flag  <= 1'b0;
    end else begin
      state     <= state_n;
      lfsr      <= lfsr_n;
      fill      <= fill_n;
      match     <= match_n;
      win_bits  <= win_bits_n;
      win_errs  <= win_errs_n;
      bit_count <= bit_cnt_n;
      err_count <= err_cnt_n;
      err_flag  <= err_flag_n;
    end
  end

  assign locked    = (state == S_LOCK);
  assign state_dbg = state;

endmodule

// File: tb/tb_mseq_ber_checker.sv
// Scoreboard bench for mseq_ber_checker: acquisition, error counting,
// loss of lock, all-zero rejection, clear, async reset and saturation.
module tb_mseq_ber_checker;

  localparam int CNT_W = 12;

  logic             clk, reset, bit_valid, bit_in, clear;
  logic             locked, err_flag;
  logic [CNT_W-1:0] bit_count, err_count;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic             lk;
    logic             fl;
    logic [CNT_W-1:0] bc;
    logic [CNT_W-1:0] ec;
    logic [1:0]       st;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Expected-behaviour bookkeeping
  logic [6:0]       hist;
  int               acq, win_pos, win_err;
  logic             m_lock;
  logic [CNT_W-1:0] m_bc, m_ec;

  mseq_ber_checker #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .clear     (clear),
    .locked    (locked),
    .err_flag  (err_flag),
    .bit_count (bit_count),
    .err_count (err_count),
    .state_dbg (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference stream s[n] = s[n-7] ^ s[n-6]; hist[k] holds s[n-1-k].
  function automatic logic next_gen();
    logic nb;
    nb   = hist[6] ^ hist[5];
    hist = {hist[5:0], nb};
    return nb;
  endfunction

  task automatic model_reset();
    acq = 0; win_pos = 0; win_err = 0;
    m_lock = 1'b0; m_bc = '0; m_ec = '0;
  endtask

  // Drive one valid bit (optionally inverted / zero / with clear), push the expectation.
  task automatic send(input logic inv, input logic clr, input logic zero, input int gap);
    logic b;
    exp_t e;
    e.fl = 1'b0;
    if (zero) begin
      b = 1'b0;
    end else begin
      b = next_gen() ^ inv;
      if (m_lock) begin
        if (m_bc != '1) m_bc = m_bc + CNT_W'(1);
        win_pos++;
        if (inv) begin
          e.fl = 1'b1;
          if (m_ec != '1) m_ec = m_ec + CNT_W'(1);
          win_err++;
        end
        if (win_err == 8) begin
          m_lock = 1'b0; acq = 0;
        end else if (win_pos == 64) begin
          win_pos = 0; win_err = 0;
        end
      end else begin
        acq++;
        if (inv && acq > 7) acq = 0;
        else if (acq == 23) begin
          m_lock = 1'b1; win_pos = 0; win_err = 0;
        end
      end
    end
    if (clr) begin
      m_bc = '0; m_ec = '0;
    end
    e.lk = m_lock;
    e.bc = m_bc;
    e.ec = m_ec;
    e.st = m_lock ? 2'b10 : ((acq >= 7) ? 2'b01 : 2'b00);
    sb_q.push_back(e);
    bit_in = b; bit_valid = 1'b1; clear = clr;
    @(negedge clk);
    bit_valid = 1'b0; clear = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      if (bit_valid) begin
        #1;
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("locked",    locked,    mon_e.lk);
          chk("err_flag",  err_flag,  mon_e.fl);
          chk("bit_count", bit_count, mon_e.bc);
          chk("err_count", err_count, mon_e.ec);
          chk("state_dbg", state_dbg, mon_e.st);
        end
      end else begin
        #1;
        chk("err_flag_idle", err_flag, 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0;
    hist = 7'b0000001;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state after idle
    repeat (10) @(negedge clk);
    chk("rst_locked",    locked,    0);
    chk("rst_err_flag",  err_flag,  0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_state",     state_dbg, 0);

    // Clean acquisition then 1000 clean bits
    for (int i = 0; i < 22; i++) send(1'b0, 1'b0, 1'b0, 4);
    chk("no_lock_at_22", locked, 0);
    send(1'b0, 1'b0, 1'b0, 4);
    chk("lock_at_23", locked, 1);
    for (int i = 0; i < 1000; i++) send(1'b0, 1'b0, 1'b0, 4);
    chk("bc_1000", bit_count, 1000);
    chk("ec_0",    err_count, 0);

    // Single error while locked
    send(1'b1, 1'b0, 1'b0, 4);
    chk("ec_1",         err_count, 1);
    chk("lock_kept",    locked,    1);
    chk("flag_dropped", err_flag,  0);
    for (int i = 0; i < 200; i++) send(1'b0, 1'b0, 1'b0, 4);
    chk("ec_still_1", err_count, 1);

    // Clear alone, then 8 errors inside one window
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_bc = '0; m_ec = '0;
    chk("clear_bc", bit_count, 0);
    chk("clear_ec", err_count, 0);
    chk("clear_keeps_lock", locked, 1);
    while (win_pos != 0) send(1'b0, 1'b0, 1'b0, 2);
    for (int i = 0; i < 7; i++) send(1'b1, 1'b0, 1'b0, 2);
    chk("lock_at_7_errs", locked, 1);
    send(1'b1, 1'b0, 1'b0, 2);
    chk("unlock_8th", locked,    0);
    chk("ec_8",       err_count, 8);
    for (int i = 0; i < 22; i++) send(1'b0, 1'b0, 1'b0, 2);
    chk("relock_not_22", locked, 0);
    send(1'b0, 1'b0, 1'b0, 2);
    chk("relock_23", locked,    1);
    chk("ec_kept_8", err_count, 8);

    // All-zero stream must never leave HUNT (504 keeps the fill phase aligned)
    do_reset();
    for (int i = 0; i < 504; i++) send(1'b0, 1'b0, 1'b1, 1);
    chk("zeros_state",  state_dbg, 0);
    chk("zeros_locked", locked,    0);
    // Error on the 10th VERIFY bit (overall bit 17), then relock 23 bits later
    for (int i = 1; i <= 17; i++) send(i == 17, 1'b0, 1'b0, 2);
    chk("verify_err_hunt", state_dbg, 0);
    for (int i = 0; i < 22; i++) send(1'b0, 1'b0, 1'b0, 2);
    chk("restart_not_22", locked, 0);
    send(1'b0, 1'b0, 1'b0, 2);
    chk("restart_lock_23", locked, 1);

    // Clear coinciding with a locked mismatch
    for (int i = 0; i < 20; i++) send(1'b0, 1'b0, 1'b0, 2);
    chk("pre_clear_bc", bit_count, 20);
    send(1'b1, 1'b1, 1'b0, 2);
    chk("clr_mis_bc", bit_count, 0);
    chk("clr_mis_ec", err_count, 0);
    for (int i = 0; i < 5; i++) send(1'b0, 1'b0, 1'b0, 2);
    chk("post_clear_bc", bit_count, 5);

    // Async reset between clock edges
    chk("pre_reset_locked", locked, 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_locked",    locked,    0);
    chk("arst_err_flag",  err_flag,  0);
    chk("arst_bit_count", bit_count, 0);
    chk("arst_err_count", err_count, 0);
    chk("arst_state",     state_dbg, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // bit_count saturation; err_count keeps counting
    for (int i = 0; i < 23; i++) send(1'b0, 1'b0, 1'b0, 1);
    for (int i = 0; i < (1 << CNT_W) + 5; i++) send(1'b0, 1'b0, 1'b0, 1);
    chk("bc_sat", bit_count, (1 << CNT_W) - 1);
    send(1'b1, 1'b0, 1'b0, 1);
    chk("bc_sat_hold", bit_count, (1 << CNT_W) - 1);
    chk("ec_after_sat", err_count, 1);
    send(1'b0, 1'b0, 1'b0, 4);

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mseq_ber_checker.md
Name: mseq_ber_checker

Overview:
Receive-side counterpart of the M-sequence generator. It consumes the decoded bit stream, self-synchronises a local LFSR replica to it, and declares lock. While locked it counts compared bits and bit errors, and drops lock on excessive errors. It sits after the convolutional decoder output and gives the measured link BER against the configured channel BER setting.

Parameters:
LFSR_W, 7, LFSR length; sequence period 2^LFSR_W-1
TAPS, 7'b1100000, feedback mask (x^7+x^6+1); must match the generator
SYNC_LEN, 16, consecutive matches in VERIFY required to enter LOCK
WIN_LEN, 64, bits per error-monitoring window in LOCK
LOSS_THRESH, 8, errors within one window that force loss of lock
CNT_W, 16, width of bit/error counters

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; clears all state
bit_valid  input  1  qualifies bit_in for one clk cycle
bit_in  input  1  decoded received bit
clear  input  1  synchronous counter clear; lock state unaffected
locked  output  1  high while in LOCK
err_flag  output  1  one-cycle pulse: mismatch evaluated in LOCK
bit_count  output  CNT_W  bits compared in LOCK, saturating
err_count  output  CNT_W  mismatches in LOCK, saturating
state_dbg  output  2  00 HUNT, 01 VERIFY, 10 LOCK

Behaviour:
- Reset (async, high): state HUNT; lfsr=0, fill=0, match=0, win_bits=0, win_errs=0; all outputs 0.
- All actions occur only on edges with bit_valid=1, except clear and err_flag deassertion. Every output is registered and updates on the edge that samples the bit; latency 1 edge.
- pred = ^(lfsr & TAPS).
- HUNT:
  - lfsr <= {lfsr[LFSR_W-2:0], bit_in}; fill++.
  - On the LFSR_W-th fill bit, go to VERIFY with match=0.
  - If the loaded value (including that bit) is all-zero, stay in HUNT with fill=0. All-zero is an illegal M-sequence state.
- VERIFY:
  - lfsr <= {lfsr[LFSR_W-2:0], pred}, free-running from the loaded seed.
  - bit_in==pred: match++. On the SYNC_LEN-th match, go to LOCK with win_bits=0 and win_errs=0.
  - Mismatch: go to HUNT with fill=0. The mismatching bit is discarded, not used as fill.
- LOCK:
  - LFSR keeps free-running; received bits never reload it, so errors do not propagate.
  - Each bit: bit_count++ (saturate at all-ones) and win_bits++.
  - Mismatch: err_count++ (saturate) and win_errs++; err_flag=1 for exactly one cycle.
  - If win_errs reaches LOSS_THRESH, go to HUNT with fill=0 on that same edge. locked falls on that edge; the counters keep their values.
  - When win_bits completes WIN_LEN bits without hitting the threshold, reset both window counters to 0.
  - The bit that caused entry to LOCK is not counted.
- locked = (state==LOCK), registered.
- err_flag is 0 on any cycle with no LOCK mismatch.
- clear=1 sets bit_count and err_count to 0.
  - Clear and bit_valid on the same edge: clear wins for the counters, but the bit still drives the FSM, LFSR, window counters and err_flag.
  - Clear does not touch window counters or state.
- Saturation: a counter at 2^CNT_W-1 holds its value; the other counter continues.
- Reset asserted mid-operation returns immediately to reset values, regardless of clk.
- Gaps in bit_valid of any length are allowed; state holds.

Test Plan:
1. Pulse reset, then idle 10 clk -> locked=0, counts=0, err_flag=0, state_dbg=00.
2. Feed a clean x^7+x^6+1 sequence from seed 7'b0000001, one bit per 4 clk -> locked rises on the 23rd valid bit (7+16). Feed 1000 more clean bits -> bit_count=1000, err_count=0.
3. While locked, invert one bit -> err_flag high exactly 1 cycle, err_count=1, locked stays 1. Send 200 more bits -> err_count still 1.
4. While locked, invert 8 bits within one 64-bit window -> locked falls on the 8th error edge and err_count=8 is retained. Resume clean bits -> relock after 23 more valid bits.
5. Feed all zeros for 500 bits -> state never leaves HUNT, locked=0. Then invert bit 10 of VERIFY during a clean acquisition -> returns to HUNT, locks 23 bits after the restart.
6. Assert clear with bit_valid and a mismatch on the same edge while locked -> err_count=0, bit_count=0, err_flag=1. Then assert async reset between clk edges while locked -> all outputs 0 immediately.
